float_to_fix: RTL and testbench

Sequential converter from half-precision float (1 sign, 5-bit biased exponent, 10-bit mantissa) to signed fix(8.8) two's complement. It is the inverse stage of the Program 1 fix(8.8)-to-float converter and consumes the 16-bit words that stage produces. It uses a start/done handshake with a one-bit-per-cycle right shifter, so latency depends on the exponent. It contains no data memory; the wrapper or testbench drives the operand and captures the result.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/float_to_fix_if.sv | 24 ++
 rtl/float_to_fix.sv | 113 +++++++++++
 tb/tb_float_to_fix.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Half-precision float field layout, exponent constants and FSM states shared by the fix<->float converters.
// Pure declarations; no latency or backpressure of its own.
package fp_pkg;

    localparam int          BIAS    = 15;
    localparam int          FRAC    = 8;
    localparam logic [4:0]  EXP_TOP = 5'(BIAS + 15 - FRAC);
    localparam logic [4:0]  EXP_MIN = 5'(BIAS - FRAC);
    localparam logic [4:0]  EXP_MAX = 5'd31;

    typedef struct packed {
        logic       sgn;
        logic [4:0] exp;
        logic [9:0] man;
    } fp16_t;

    typedef enum logic [1:0] {
        IDLE,
        CLASSIFY,
        SHIFT,
        FINISH
    } state_t;

    // Saturated fix(8.8) value for the given sign.
    function automatic logic [15:0] sat_value(input logic sgn);
        return sgn ? 16'h8000 : 16'h7FFF;
    endfunction

    // Right-shift distance that puts the hidden one at its fix(8.8) weight.
    function automatic logic [3:0] shift_count(input logic [4:0] exp);
        return 4'(EXP_TOP - exp);
    endfunction

endpackage

// File: rtl/float_to_fix_if.sv
// Start/done handshake and data bus between a requester and the float_to_fix converter.
// Requester drives start/flt_in; converter drives result and status flags.
interface float_to_fix_if;
    import fp_pkg::*;

    logic        start;
    fp16_t       flt_in;
    logic [15:0] fix_out;
    logic        done;
    logic        busy;
    logic        ovf;
    logic        inexact;

    modport master (
        output start, flt_in,
        input  fix_out, done, busy, ovf, inexact
    );

    modport slave (
        input  start, flt_in,
        output fix_out, done, busy, ovf, inexact
    );

endinterface

// File: rtl/float_to_fix.sv
// Half float to signed fix(8.8) with truncation toward zero and saturation.
// Latency 3+k edges (k = EXP_TOP-exp for normals, 0 for specials); start is ignored while busy.
module float_to_fix
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    float_to_fix_if.slave  bus
);

    state_t      state;
    fp16_t       op;
    logic [15:0] mag;
    logic [3:0]  ctr;
    logic        special;
    logic [15:0] spec_res;
    logic [15:0] fix_q;
    logic        done_q;
    logic        busy_q;
    logic        ovf_q;
    logic        inexact_q;

    assign bus.fix_out = fix_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.ovf     = ovf_q;
    assign bus.inexact = inexact_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= '0;
            mag       <= '0;
            ctr       <= '0;
            special   <= 1'b0;
            spec_res  <= '0;
            fix_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op        <= bus.flt_in;
                        done_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        inexact_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= CLASSIFY;
                    end
                end

                CLASSIFY: begin
                    special <= 1'b1;
                    ctr     <= '0;
                    mag     <= '0;
                    state   <= FINISH;
                    if (op.exp == 5'd0) begin
                        // Zero and denormals flush to zero.
                        spec_res  <= '0;
                        inexact_q <= (op.man != 10'd0);
                    end else if (op.exp == EXP_MAX || op.exp > EXP_TOP) begin
                        spec_res <= sat_value(op.sgn);
                        ovf_q    <= 1'b1;
                    end else if (op.exp == EXP_TOP) begin
                        // -128.0 is the one exactly representable value at this exponent.
                        if (op.sgn && op.man == 10'd0) begin
                            spec_res <= 16'h8000;
                        end else begin
                            spec_res <= sat_value(op.sgn);
                            ovf_q    <= 1'b1;
                        end
                    end else if (op.exp < EXP_MIN) begin
                        spec_res  <= '0;
                        inexact_q <= 1'b1;
                    end else begin
                        special <= 1'b0;
                        mag     <= {1'b1, op.man, 5'b0};
                        ctr     <= shift_count(op.exp);
                        if (shift_count(op.exp) != 4'd0) begin
                            state <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    mag       <= mag >> 1;
                    ctr       <= ctr - 4'd1;
                    inexact_q <= inexact_q | mag[0];
                    if (ctr == 4'd1) begin
                        state <= FINISH;
                    end
                end

                FINISH: begin
                    if (special) begin
                        fix_q <= spec_res;
                    end else begin
                        fix_q <= op.sgn ? (~mag + 16'd1) : mag;
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fix.sv
// Directed and round-trip checks of float_to_fix through a result scoreboard.
module tb_float_to_fix;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    float_to_fix_if bus();

    float_to_fix dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] fix;
        logic        ovf;
        logic        inexact;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Independent fix(8.8) -> half float model (truncating), plus what converting back must give.
    task automatic rt_model(input logic [15:0] fx, output logic [15:0] flt, output exp_t e);
        logic        s;
        logic [15:0] m;
        logic [15:0] norm;
        logic [15:0] t;
        int          p;
        s = fx[15];
        m = s ? (16'd0 - fx) : fx;
        p = -1;
        for (int b = 0; b < 16; b++) if (m[b]) p = b;
        if (p < 0) begin
            flt = 16'h0000;
            e   = '{fix: 16'h0000, ovf: 1'b0, inexact: 1'b0, lat: 3};
        end else begin
            norm = m << (15 - p);
            flt  = {s, 5'(p + 7), norm[14:5]};
            t    = (p > 10) ? (m & ~((16'd1 << (p - 10)) - 16'd1)) : m;
            e    = '{fix: (s ? (16'd0 - t) : t), ovf: 1'b0, inexact: 1'b0, lat: 3 + (15 - p)};
        end
    endtask

    task automatic run_op(input logic [15:0] f, input exp_t e, input bit poke, input string tag);
        int   lat;
        bit   seen;
        exp_t got;
        sb.push_back(e);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flt_in = f;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.flt_in = 16'h0000;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) seen = 1'b1;
            else if (poke) begin
                bus.start  = 1'b1;
                bus.flt_in = 16'h5800;
            end
        end
        bus.start = 1'b0;
        got = sb.pop_front();
        if (!seen) lat = -1;
        chk({tag, "_lat"},     32'(lat),         32'(got.lat));
        chk({tag, "_fix"},     32'(bus.fix_out), 32'(got.fix));
        chk({tag, "_ovf"},     32'(bus.ovf),     32'(got.ovf));
        chk({tag, "_inexact"}, 32'(bus.inexact), 32'(got.inexact));
        chk({tag, "_busy"},    32'(bus.busy),    32'd0);
    endtask

    initial begin
        logic [15:0] flt;
        logic [15:0] fx;
        exp_t        e;

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.flt_in = 16'h0000;
        #12;
        chk("rst_fix",     32'(bus.fix_out), 32'h0);
        chk("rst_done",    32'(bus.done),    32'h0);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_ovf",     32'(bus.ovf),     32'h0);
        chk("rst_inexact", 32'(bus.inexact), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        run_op(16'h3C00, '{fix: 16'h0100, ovf: 1'b0, inexact: 1'b0, lat: 10}, 1'b0, "one");
        run_op(16'hBE00, '{fix: 16'hFE80, ovf: 1'b0, inexact: 1'b0, lat: 10}, 1'b0, "neg1p5");
        run_op(16'hD800, '{fix: 16'h8000, ovf: 1'b0, inexact: 1'b0, lat: 3},  1'b0, "neg128");
        run_op(16'h5800, '{fix: 16'h7FFF, ovf: 1'b1, inexact: 1'b0, lat: 3},  1'b0, "pos128");
        run_op(16'h7C00, '{fix: 16'h7FFF, ovf: 1'b1, inexact: 1'b0, lat: 3},  1'b0, "inf");
        run_op(16'hFC00, '{fix: 16'h8000, ovf: 1'b1, inexact: 1'b0, lat: 3},  1'b0, "ninf");
        run_op(16'h1C00, '{fix: 16'h0001, ovf: 1'b0, inexact: 1'b0, lat: 18}, 1'b0, "lsb");
        run_op(16'h1800, '{fix: 16'h0000, ovf: 1'b0, inexact: 1'b1, lat: 3},  1'b0, "tiny");
        run_op(16'h0000, '{fix: 16'h0000, ovf: 1'b0, inexact: 1'b0, lat: 3},  1'b0, "zero");
        run_op(16'h0001, '{fix: 16'h0000, ovf: 1'b0, inexact: 1'b1, lat: 3},  1'b0, "denorm");
        run_op(16'h3C01, '{fix: 16'h0100, ovf: 1'b0, inexact: 1'b1, lat: 10}, 1'b0, "trunc");

        // Abort a long conversion with reset while it is shifting.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flt_in = 16'h1C00;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_done", 32'(bus.done),    32'h0);
        chk("abort_busy", 32'(bus.busy),    32'h0);
        chk("abort_fix",  32'(bus.fix_out), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_op(16'h3C00, '{fix: 16'h0100, ovf: 1'b0, inexact: 1'b0, lat: 10}, 1'b0, "after_abort");

        // Start held high with a different operand while busy must not disturb the result.
        run_op(16'h3C00, '{fix: 16'h0100, ovf: 1'b0, inexact: 1'b0, lat: 10}, 1'b1, "busy_start");
        repeat (2) @(negedge clk);
        chk("hold_fix",  32'(bus.fix_out), 32'h0100);
        chk("hold_done", 32'(bus.done),    32'h1);

        for (int n = 0; n < 64; n++) begin
            fx = 16'($urandom);
            rt_model(fx, flt, e);
            run_op(flt, e, 1'b0, "roundtrip");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
